// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: scan states, segment constants and hex decode
// table shared by the multiplexed 7-segment scan controller.
package seven_seg_pkg;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  // all segments dark (segments are active-low)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // {g,f,e,d,c,b,a}, active-low, indexed by hex nibble
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// seven_seg_hex_decoder: combinational nibble to
// active-low segment pattern lookup.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // table lookup, no state
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: blanked, tear-free digit scan.
// Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN darks leading zeros.
module seven_seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  output logic                    o_busy,
  output logic [6:0]              o_digitalTube,
  output logic [NUM_DIGITS-1:0]   o_sel,
  output logic                    o_frame
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX_A =
    (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CMAX = (CMAX_A > 2) ? CMAX_A : 2;
  localparam int CW = $clog2(CMAX);

  localparam logic [CW-1:0] SHOW_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nx;
  logic            wrap;

  logic [DW-1:0]   display_reg;
  logic [DW-1:0]   disp_nx;
  logic [DW-1:0]   shadow;
  logic [DW-1:0]   shadow_nx;
  logic            pending;
  logic            pending_nx;
  logic            commit;

  logic [3:0]      nib;
  logic [6:0]      dec_seg;
  logic            lead_blank;
  logic [6:0]      seg_nx;
  logic [NUM_DIGITS-1:0] sel_nx;

  // next scan position; wrap flags the last lit
  // cycle of the final digit (frame end)
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    wrap     = 1'b0;
    if (!i_enable) begin
      state_nx = S_BLANK;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      unique case (state)
        S_BLANK: begin
          if (NO_BLANK || cnt == BLANK_LAST) begin
            state_nx = S_SHOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_nx   = '0;
            state_nx = NO_BLANK ? S_SHOW : S_BLANK;
            if (idx == IDX_LAST) begin
              idx_nx = '0;
              wrap   = 1'b1;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // commit at frame end, or at once while disabled;
  // a load in the same cycle lands in shadow
  always_comb begin
    commit     = i_enable ? wrap : 1'b1;
    disp_nx    = (commit && pending) ? shadow
                                     : display_reg;
    shadow_nx  = i_load ? i_value : shadow;
    pending_nx = i_load || (pending && !commit);
  end

  // nibble of the digit that is lit next cycle
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nx == IW'(k)) begin
        nib = disp_nx[4*k +: 4];
      end
    end
  end

  seven_seg_hex_decoder u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // digits above the top nonzero nibble stay dark;
  // digit 0 is never above msd so "0" still shows
  always_comb begin
    msd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_nx[4*k +: 4] != 4'h0) begin
        msd = IW'(k);
      end
    end
    lead_blank = (idx_nx > msd);
  end
`else
  assign lead_blank = 1'b0;
`endif

  // outputs are computed from the next position so
  // the registered pins line up with the FSM state
  always_comb begin
    seg_nx = SEG_OFF;
    sel_nx = '1;
    if (state_nx == S_SHOW) begin
      seg_nx = lead_blank ? SEG_OFF : dec_seg;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_nx == IW'(k)) begin
          sel_nx[k] = 1'b0;
        end
      end
    end
  end

  // scan position registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // value registers: shadow, pending flag, display
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      display_reg <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      display_reg <= disp_nx;
      shadow      <= shadow_nx;
      pending     <= pending_nx;
    end
  end

  // registered output pins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_digitalTube <= SEG_OFF;
      o_sel         <= '1;
      o_busy        <= 1'b0;
      o_frame       <= 1'b0;
    end else begin
      o_digitalTube <= seg_nx;
      o_sel         <= sel_nx;
      o_busy        <= pending_nx;
      o_frame       <= wrap;
    end
  end

endmodule
